fsqrt: RTL and testbench
========================

FSQRT -- requirements
Module: fsqrt

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: x  input  32  IEEE-754 binary32 operand {sign, exp[7:0], man[22:0]}.
REQ-004 SHALL have ports: valid_in  input  1  operand x qualifies this cycle.
REQ-005 SHALL have ports: y  output  32  binary32 square root of x.
REQ-006 SHALL have ports: valid_out  output  1  y and exception valid this cycle.
REQ-007 SHALL have ports: exception  output  1  invalid/NaN flag; present only with FSQRT_EXC_EN.
REQ-008 SHALL have no parameters; the binary32 format is fixed.

Function
REQ-009 SHALL have a latency of exactly 1 cycle: x sampled on clk edge N with valid_in=1 gives y/valid_out=1 after edge N.
REQ-010 SHALL accept a new operand every cycle (throughput 1); valid_in=0 gives valid_out=0 next cycle, and y holds its previous value.
REQ-011 SHALL, for normal positive x, produce y within ±1 of the correctly rounded (round-to-nearest-even) bit pattern; nearest-even is the target.
REQ-012 SHALL fully support subnormal inputs (exp=0, man≠0): normalize via leading-zero count, then take the root; the result is always normal, and no flush-to-zero is allowed.
REQ-013 SHALL compute the result exponent as floor((e_unbiased)/2)+127; for odd unbiased exponents, the mantissa is pre-shifted left 1 bit before the root.
REQ-014 SHALL compute the mantissa root to at least 24 bits plus guard and sticky bits, for example by digit-recurrence.
REQ-015 SHALL handle +0 → +0 (0x00000000) and -0 → -0 (0x80000000), with exception=0.
REQ-016 SHALL handle +inf (0x7F800000) → +inf, with exception=0.
REQ-017 SHALL handle NaN input (exp=255, man≠0) → x with bit 22 forced to 1 (quieted, sign and payload kept), with exception=1.
REQ-018 SHALL handle negative nonzero input (including -inf and negative subnormals) → 0xFFC00000, with exception=1.
REQ-019 SHALL produce y that is never subnormal, inf, or NaN for finite non-negative x.

Reset
REQ-020 SHALL, while rst=1 at a clk edge, force y=0x00000000, valid_out=0, and exception=0.
REQ-021 SHALL discard any operand sampled in the same cycle as rst; the first valid result appears 1 cycle after the first valid_in following rst release.

Configuration
REQ-022 SHALL, with FSQRT_EXC_EN defined, have the exception port registered alongside y per REQ-015..018.
REQ-023 SHALL, with FSQRT_EXC_EN undefined, omit the exception port; y behaviour is identical.

Structure
REQ-024 SHALL place shared items in package fpu_pkg: field widths (EXP_W=8, MAN_W=23, BIAS=127), constants QNAN_NEG=0xFFC00000, POS_INF=0x7F800000, and a binary32 struct typedef.
REQ-025 SHALL contain one combinational sub-module fsqrt_core: normalized mantissa in → rounded 24-bit root out; fsqrt does classification, exponent, special cases, and the output register.
REQ-026 SHALL target 120–400 RTL lines in total.

Verification
REQ-027 SHALL cover: x=0x40800000 (4.0) → y=0x40000000 exactly, exception=0, after 1 cycle.
REQ-028 SHALL cover: x=0x40000000 (2.0) → y=0x3FB504F3 ±1; x=0x3F800000 → 0x3F800000.
REQ-029 SHALL cover: x=0x00000001 (min subnormal) → y=0x1A3504F3 ±1; x=0x80000000 → 0x80000000.
REQ-030 SHALL cover: x=0xBF800000 → 0xFFC00000 with exception=1; x=0x7F800001 → 0x7FC00001 with exception=1; x=0x7F800000 → 0x7F800000.
REQ-031 SHALL cover a sweep of all 256 exponents × both signs × mantissas {0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF, random}, each y within ±1 of the reference sqrt bit pattern.
REQ-032 SHALL cover: rst asserted with valid_in=1 → next cycle valid_out=0 and y=0; back-to-back valid_in gives results on consecutive cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, special encodings and helpers for the FPU blocks.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN_NEG = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Leading-zero count of a 24-bit word; returns 24 for an all-zero word.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fsqrt_core.sv
// Combinational mantissa square root: restoring digit recurrence with guard and
// sticky, rounded to nearest-even, producing a 24-bit root in [2^23, 2^24).
module fsqrt_core
  import fpu_pkg::*;
(
  input  logic [23:0] i_man,
  input  logic        i_odd,
  output logic [23:0] o_root
);

  logic [49:0] w_rad;
  logic [24:0] w_q;
  logic [26:0] w_rem;

  // Odd exponents pre-shift one extra bit so the root lands in [sqrt2, 2).
  assign w_rad = i_odd ? {i_man, 26'd0} : {1'b0, i_man, 25'd0};

  always_comb begin
    logic [26:0] rem;
    logic [26:0] trial;
    logic [24:0] q;
    rem = '0;
    q   = '0;
    for (int i = 24; i >= 0; i--) begin
      rem   = {rem[24:0], w_rad[2*i+1 -: 2]};
      trial = {q, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        q   = {q[23:0], 1'b1};
      end else begin
        q   = {q[23:0], 1'b0};
      end
    end
    w_q   = q;
    w_rem = rem;
  end

  // q[0] is the guard bit; any nonzero remainder is the sticky bit.
  assign o_root = w_q[24:1] + {23'd0, w_q[0] & ((|w_rem) | w_q[1])};

endmodule

// File: rtl/fsqrt.sv
// Single-cycle binary32 square root: classification, exponent, special cases and
// output register. FSQRT_EXC_EN adds the registered invalid/NaN exception port.
module fsqrt
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        valid_in,
  output logic [31:0] y,
  output logic        valid_out
`ifdef FSQRT_EXC_EN
  ,
  output logic        exception
`endif
);

  fp32_t       w_x;
  logic        w_is_zero;
  logic        w_is_sub;
  logic        w_is_infnan;
  logic        w_is_nan;
  logic [4:0]  w_lz;
  logic [23:0] w_man_norm;
  logic [8:0]  w_eb;
  logic [23:0] w_root;
  logic [31:0] w_y_fin;
  logic [31:0] w_y;
  logic [31:0] r_y;
  logic        r_valid;

  assign w_x         = x;
  assign w_is_zero   = (w_x.exp == '0) && (w_x.man == '0);
  assign w_is_sub    = (w_x.exp == '0) && (w_x.man != '0);
  assign w_is_infnan = (w_x.exp == '1);
  assign w_is_nan    = w_is_infnan && (w_x.man != '0);

  assign w_lz       = lzc24({1'b0, w_x.man});
  assign w_man_norm = w_is_sub ? ({1'b0, w_x.man} << w_lz) : {1'b1, w_x.man};

  // w_eb = e_unbiased + 254, so w_eb>>1 is floor(e/2)+127 and w_eb[0] flags an odd e.
  assign w_eb = w_is_sub ? (9'd128 - {4'd0, w_lz})
                         : ({1'b0, w_x.exp} + 9'(BIAS));

  fsqrt_core u_core (
    .i_man  (w_man_norm),
    .i_odd  (w_eb[0]),
    .o_root (w_root)
  );

  // The root's hidden bit carries into the exponent field, hence the minus one.
  assign w_y_fin = {1'b0, w_eb[8:1] - 8'd1, 23'd0} + {8'd0, w_root};

  always_comb begin
    w_y = w_y_fin;
    if (w_is_nan) begin
      w_y = x | 32'h0040_0000;
    end else if (w_is_zero) begin
      w_y = x;
    end else if (w_x.sign) begin
      w_y = QNAN_NEG;
    end else if (w_is_infnan) begin
      w_y = POS_INF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_y <= w_y;
      end
    end
  end

  assign y         = r_y;
  assign valid_out = r_valid;

`ifdef FSQRT_EXC_EN
  logic w_exc;
  logic r_exc;

  assign w_exc = w_is_nan | (w_x.sign & ~w_is_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc <= 1'b0;
    end else if (valid_in) begin
      r_exc <= w_exc;
    end
  end

  assign exception = r_exc;
`endif

endmodule

// File: tb/tb_fsqrt.sv
// Scoreboard bench for fsqrt: real-arithmetic reference model, randomized and
// directed operands, one expected entry per cycle popped by a negedge monitor.
module tb_fsqrt;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        valid_in;
  logic [31:0] y;
  logic        valid_out;
`ifdef FSQRT_EXC_EN
  logic        exception;
`endif

  always #5 clk = ~clk;

  fsqrt dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .valid_in  (valid_in),
    .y         (y),
    .valid_out (valid_out)
`ifdef FSQRT_EXC_EN
    ,
    .exception (exception)
`endif
  );

  typedef enum {K_VALID, K_IDLE, K_RST} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] x;
    logic [31:0] y;
    logic        exc;
    int          tol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference: decode to a real, take $sqrt, re-encode with round-half-up.
  function automatic void ref_sqrt(input logic [31:0] a, output logic [31:0] r,
                                   output logic exc, output int tol);
    int     ex;
    int     mn;
    int     e;
    real    v;
    real    s;
    real    f;
    longint q;
    ex  = int'(a[30:23]);
    mn  = int'(a[22:0]);
    exc = 1'b0;
    tol = 0;
    r   = 32'd0;
    if (ex == 255 && mn != 0) begin
      r   = a | 32'h0040_0000;
      exc = 1'b1;
    end else if (a[30:0] == 31'd0) begin
      r = a;
    end else if (a[31]) begin
      r   = 32'hFFC0_0000;
      exc = 1'b1;
    end else if (ex == 255) begin
      r = 32'h7F80_0000;
    end else begin
      if (ex == 0) v = real'(mn) * pow2(-149);
      else         v = (real'(mn) + 8388608.0) * pow2(ex - 150);
      s = $sqrt(v);
      e = 0;
      while (s >= pow2(e + 1)) e++;
      while (s < pow2(e)) e--;
      f = s / pow2(e) * 8388608.0;
      q = longint'($floor(f + 0.5));
      if (q >= 64'd16777216) begin
        q = q / 2;
        e++;
      end
      r   = {1'b0, 8'(e + 127), q[22:0]};
      tol = 1;
    end
  endfunction

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input bit exact);
    exp_t        en;
    logic [31:0] r;
    logic        ex;
    int          t;
    ref_sqrt(a, r, ex, t);
    rst      = 1'b0;
    valid_in = 1'b1;
    x        = a;
    en.kind  = K_VALID;
    en.x     = a;
    en.y     = r;
    en.exc   = ex;
    en.tol   = exact ? 0 : t;
    sb.push_back(en);
    step();
  endtask

  task automatic idle();
    exp_t en;
    rst      = 1'b0;
    valid_in = 1'b0;
    x        = $urandom;
    en.kind  = K_IDLE;
    en.x     = 32'd0;
    en.y     = 32'd0;
    en.exc   = 1'b0;
    en.tol   = 0;
    sb.push_back(en);
    step();
  endtask

  task automatic reset_cycle(input bit vin);
    exp_t en;
    rst      = 1'b1;
    valid_in = vin;
    x        = 32'h4080_0000;
    en.kind  = K_RST;
    en.x     = 32'd0;
    en.y     = 32'd0;
    en.exc   = 1'b0;
    en.tol   = 0;
    sb.push_back(en);
    step();
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin : monitor
    logic [31:0] hold;
    bit          hold_known;
    exp_t        en;
    longint      d;
    hold       = 32'd0;
    hold_known = 1'b0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk(valid_out === 1'b0, "spurious_valid", {31'd0, valid_out}, 32'd0);
      end else begin
        en = sb.pop_front();
        case (en.kind)
          K_RST: begin
            chk(valid_out === 1'b0, "rst_valid_out", {31'd0, valid_out}, 32'd0);
            chk(y === 32'd0, "rst_y", y, 32'd0);
`ifdef FSQRT_EXC_EN
            chk(exception === 1'b0, "rst_exception", {31'd0, exception}, 32'd0);
`endif
            hold       = 32'd0;
            hold_known = 1'b1;
          end
          K_IDLE: begin
            chk(valid_out === 1'b0, "idle_valid_out", {31'd0, valid_out}, 32'd0);
            if (hold_known) chk(y === hold, "idle_hold_y", y, hold);
          end
          default: begin
            chk(valid_out === 1'b1, "valid_out", {31'd0, valid_out}, 32'd1);
            d = longint'(y) - longint'(en.y);
            if (d < 0) d = -d;
            chk(!$isunknown(y) && d <= longint'(en.tol), "sqrt_y", y, en.y);
`ifdef FSQRT_EXC_EN
            chk(exception === en.exc, "exception", {31'd0, exception}, {31'd0, en.exc});
`endif
            $display("txn x=%08h y=%08h ref=%08h tol=%0d", en.x, y, en.y, en.tol);
            hold       = en.y;
            hold_known = (en.tol == 0);
          end
        endcase
      end
    end
  end

  initial begin : stimulus
    logic [22:0] mans[8];
    rst      = 1'b1;
    valid_in = 1'b0;
    x        = 32'd0;

    reset_cycle(1'b1);
    reset_cycle(1'b1);
    reset_cycle(1'b0);
    idle();

    issue(32'h4080_0000, 1'b1);
    idle();
    issue(32'h4000_0000, 1'b0);
    issue(32'h3F80_0000, 1'b1);
    idle();
    issue(32'h0000_0001, 1'b0);
    issue(32'h8000_0000, 1'b1);
    idle();
    issue(32'hBF80_0000, 1'b1);
    issue(32'h7F80_0001, 1'b1);
    issue(32'h7F80_0000, 1'b1);
    idle();

    mans[0] = 23'h000000;
    mans[1] = 23'h000001;
    mans[2] = 23'h000002;
    mans[3] = 23'h380000;
    mans[4] = 23'h400000;
    mans[5] = 23'h5FFFFF;
    mans[6] = 23'h7FFFFF;
    for (int e = 0; e < 256; e++) begin
      for (int s = 0; s < 2; s++) begin
        mans[7] = 23'($urandom);
        for (int m = 0; m < 8; m++) begin
          issue({1'(s), 8'(e), mans[m]}, 1'b0);
        end
      end
    end

    issue(32'h4110_0000, 1'b0);
    reset_cycle(1'b1);
    idle();
    issue(32'h4080_0000, 1'b1);
    idle();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue($urandom, 1'b0);
    end

    idle();
    idle();
    repeat (4) step();
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
